cache_ctrl: RTL

Initiator for the cache chip-select/read/write/replace port. Accepts single-word CPU requests and issues cache lookups. On a read miss it fetches the word from main memory over a req/ack handshake, then refills the cache with a replace (rpe) cycle. Write-through, no write-allocate. Sits between the CPU core, the cache module and the main-memory port.

---
 rtl/cache_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// Cache controller: single-word CPU requests, write-through cache lookups, read-miss refill from memory.
// Optional hit/miss counters are enabled with the CACHE_STATS_EN macro.
module cache_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  cs,
    output logic                  we,
    output logic                  re,
    output logic                  rpe,
    input  logic                  hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef CACHE_STATS_EN
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`else
    input  logic                  mem_ack
`endif
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MEM_RD, REFILL, WR_CACHE, MEM_WR, DONE
    } state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0] addr_d, mem_addr_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_d, mem_wdata_d;
    logic                  cs_d, we_d, re_d, rpe_d, mem_req_d, mem_we_d, cpu_ready_d;

    // word_q holds the write data, or the refill word once memory returns it
    assign data = (cs && (we || rpe) && !re) ? word_q : {DATA_WIDTH{1'bz}};

    always_comb begin
        state_d     = state;
        word_d      = word_q;
        addr_d      = addr;
        cpu_rdata_d = cpu_rdata;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    word_d  = cpu_wdata;
                    state_d = cpu_we ? WR_CACHE : LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_rdata_d = data;
                    state_d     = DONE;
                end else begin
                    mem_addr_d = addr;
                    state_d    = MEM_RD;
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    word_d      = mem_rdata;
                    cpu_rdata_d = mem_rdata;
                    state_d     = REFILL;
                end
            end
            REFILL:   state_d = DONE;
            WR_CACHE: begin
                mem_addr_d  = addr;
                mem_wdata_d = word_q;
                state_d     = MEM_WR;
            end
            MEM_WR:   if (mem_ack) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Moore strobes decoded from the next state so they register alongside it
        cs_d        = (state_d == LOOKUP) || (state_d == REFILL) || (state_d == WR_CACHE);
        re_d        = (state_d == LOOKUP);
        we_d        = (state_d == WR_CACHE);
        rpe_d       = (state_d == REFILL);
        mem_req_d   = (state_d == MEM_RD) || (state_d == MEM_WR);
        mem_we_d    = (state_d == MEM_WR);
        cpu_ready_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            word_q    <= '0;
            addr      <= '0;
            cpu_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cs        <= 1'b0;
            we        <= 1'b0;
            re        <= 1'b0;
            rpe       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ready <= 1'b0;
        end else begin
            state     <= state_d;
            word_q    <= word_d;
            addr      <= addr_d;
            cpu_rdata <= cpu_rdata_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            cs        <= cs_d;
            we        <= we_d;
            re        <= re_d;
            rpe       <= rpe_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            cpu_ready <= cpu_ready_d;
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating lookup outcome counters; writes never pass through LOOKUP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
